// File: rtl/vid_wr_scheduler.sv
// Video frame-buffer write scheduler: issues one AXI burst request per line and
// rotates between three frame buffers while avoiding the buffer being scanned out.
module vid_wr_scheduler #(
  parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0040_0000,
  parameter int unsigned LINE_BYTES   = 5120,
  parameter int unsigned LINES        = 720
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        FRAME_SYNC,
  input  logic [10:0] FIFO_RD_COUNT,
  input  logic        WR_READY,
  output logic        WR_START,
  output logic [31:0] WR_ADRS,
  output logic [31:0] WR_LEN,
  input  logic        WR_DONE,
  input  logic [1:0]  RD_ACTIVE_IDX,
  output logic [1:0]  WR_BUF_IDX,
  output logic [1:0]  LAST_BUF_IDX,
  output logic        FRAME_DONE,
  output logic        OVERRUN,
  output logic        BUSY
);

  localparam int unsigned      CNT_W      = $clog2(LINES + 1);
  localparam logic [CNT_W-1:0] LINES_CNT  = CNT_W'(LINES);
  localparam logic [10:0]      LINE_WORDS = 11'(LINE_BYTES / 8);
  localparam logic [31:0]      LINE_LEN   = 32'(LINE_BYTES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    FRAME_END = 3'd4
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   line_cnt_q;
  logic [31:0]        line_addr_q;
  logic               wr_start_q;
  logic [31:0]        wr_adrs_q;
  logic [1:0]         buf_idx_q;
  logic [1:0]         last_idx_q;
  logic               frame_done_q;
  logic               overrun_q;
  logic               busy_q;
  logic               resync_pend_q;
  logic               start_pend_q;

  logic [CNT_W-1:0]   line_cnt_d;
  logic               last_line_d;
  logic [31:0]        buf_base_d;
  logic [1:0]         next_buf_d;
  logic               fifo_ok_d;
  logic [31:0]        line_addr_d;

  function automatic logic [1:0] mod3_inc(input logic [1:0] idx);
    logic [1:0] r;
    case (idx)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Skipping the scanned-out buffer once is enough: with three buffers the
  // second candidate can match neither the reader nor the outgoing buffer.
  function automatic logic [1:0] rotate(input logic [1:0] cur, input logic [1:0] rd);
    logic [1:0] cand;
    cand = mod3_inc(cur);
    if (cand == rd) begin
      cand = mod3_inc(cand);
    end else begin
      cand = cand;
    end
    return cand;
  endfunction

  function automatic logic [31:0] buf_base(input logic [1:0] idx);
    logic [31:0] r;
    case (idx)
      2'd1:    r = BASE_ADDR + FRAME_STRIDE;
      2'd2:    r = BASE_ADDR + (FRAME_STRIDE << 1);
      default: r = BASE_ADDR;
    endcase
    return r;
  endfunction

  assign line_cnt_d  = line_cnt_q + CNT_W'(1);
  assign last_line_d = (line_cnt_d == LINES_CNT);
  assign line_addr_d = line_addr_q + LINE_LEN;
  assign buf_base_d  = buf_base(buf_idx_q);
  assign next_buf_d  = rotate(buf_idx_q, RD_ACTIVE_IDX);
  assign fifo_ok_d   = (FIFO_RD_COUNT >= LINE_WORDS);

  // Line/frame sequencing FSM with all outputs registered.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= IDLE;
      line_cnt_q    <= '0;
      line_addr_q   <= BASE_ADDR;
      wr_start_q    <= 1'b0;
      wr_adrs_q     <= BASE_ADDR;
      buf_idx_q     <= 2'd0;
      last_idx_q    <= 2'd2;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
      resync_pend_q <= 1'b0;
      start_pend_q  <= 1'b0;
    end else begin
      wr_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (FRAME_SYNC || start_pend_q) begin
            state_q      <= WAIT_DATA;
            busy_q       <= 1'b1;
            line_cnt_q   <= '0;
            line_addr_q  <= buf_base_d;
            start_pend_q <= 1'b0;
          end
        end
        WAIT_DATA: begin
          if (FRAME_SYNC) begin
            overrun_q   <= 1'b1;
            line_cnt_q  <= '0;
            line_addr_q <= buf_base_d;
          end else if (fifo_ok_d && WR_READY) begin
            state_q    <= START;
            wr_start_q <= 1'b1;
            wr_adrs_q  <= line_addr_q;
          end
        end
        START: begin
          state_q <= WAIT_DONE;
          if (FRAME_SYNC) begin
            overrun_q     <= 1'b1;
            resync_pend_q <= 1'b1;
          end
        end
        WAIT_DONE: begin
          if (WR_DONE) begin
            // A pending resync aborts the frame even if this was its last line.
            if (resync_pend_q || (FRAME_SYNC && !last_line_d)) begin
              state_q       <= WAIT_DATA;
              line_cnt_q    <= '0;
              line_addr_q   <= buf_base_d;
              resync_pend_q <= 1'b0;
              if (FRAME_SYNC) begin
                overrun_q <= 1'b1;
              end
            end else if (last_line_d) begin
              state_q      <= FRAME_END;
              frame_done_q <= 1'b1;
              line_cnt_q   <= line_cnt_d;
              line_addr_q  <= line_addr_d;
              if (FRAME_SYNC) begin
                overrun_q    <= 1'b1;
                start_pend_q <= 1'b1;
              end
            end else begin
              state_q     <= WAIT_DATA;
              line_cnt_q  <= line_cnt_d;
              line_addr_q <= line_addr_d;
            end
          end else if (FRAME_SYNC) begin
            overrun_q     <= 1'b1;
            resync_pend_q <= 1'b1;
          end
        end
        FRAME_END: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          last_idx_q <= buf_idx_q;
          buf_idx_q  <= next_buf_d;
          if (FRAME_SYNC) begin
            start_pend_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign WR_START     = wr_start_q;
  assign WR_ADRS      = wr_adrs_q;
  assign WR_LEN       = LINE_LEN;
  assign WR_BUF_IDX   = buf_idx_q;
  assign LAST_BUF_IDX = last_idx_q;
  assign FRAME_DONE   = frame_done_q;
  assign OVERRUN      = overrun_q;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_vid_wr_scheduler.sv
// Self-checking bench for vid_wr_scheduler (LINES=4, LINE_BYTES=64) using a
// frame-level reference model: address = base + buffer*stride + line*bytes.
module tb_vid_wr_scheduler;
  localparam logic [31:0] BASE   = 32'h0100_0000;
  localparam logic [31:0] STRIDE = 32'h0040_0000;
  localparam int          LBYTES = 64;
  localparam int          NLINES = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        FRAME_SYNC = 1'b0;
  logic [10:0] FIFO_RD_COUNT = 11'd8;
  logic        WR_READY = 1'b1;
  logic        WR_DONE = 1'b0;
  logic [1:0]  RD_ACTIVE_IDX = 2'd2;
  logic        WR_START;
  logic [31:0] WR_ADRS;
  logic [31:0] WR_LEN;
  logic [1:0]  WR_BUF_IDX;
  logic [1:0]  LAST_BUF_IDX;
  logic        FRAME_DONE;
  logic        OVERRUN;
  logic        BUSY;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int ws_count = 0;
  int m_buf = 0;
  int m_last = 2;

  vid_wr_scheduler #(
    .BASE_ADDR(BASE), .FRAME_STRIDE(STRIDE), .LINE_BYTES(LBYTES), .LINES(NLINES)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .FRAME_SYNC(FRAME_SYNC), .FIFO_RD_COUNT(FIFO_RD_COUNT),
    .WR_READY(WR_READY), .WR_START(WR_START), .WR_ADRS(WR_ADRS), .WR_LEN(WR_LEN),
    .WR_DONE(WR_DONE), .RD_ACTIVE_IDX(RD_ACTIVE_IDX), .WR_BUF_IDX(WR_BUF_IDX),
    .LAST_BUF_IDX(LAST_BUF_IDX), .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (FRAME_DONE === 1'b1) fd_count <= fd_count + 1;
    if (WR_START === 1'b1) ws_count <= ws_count + 1;
  end

  function automatic logic [31:0] exp_addr(input int b, input int line);
    return BASE + STRIDE * 32'(b) + 32'(LBYTES * line);
  endfunction

  function automatic int next_buf(input int cur, input int rd);
    int c;
    c = (cur + 1) % 3;
    if (c == rd) c = (c + 1) % 3;
    return c;
  endfunction

  task automatic apply_reset();
    @(negedge ACLK);
    ARESET = 1'b1; FRAME_SYNC = 1'b0; WR_DONE = 1'b0;
    FIFO_RD_COUNT = 11'd8; WR_READY = 1'b1; RD_ACTIVE_IDX = 2'd2;
    @(negedge ACLK);
    ARESET = 1'b0;
    m_buf = 0; m_last = 2;
  endtask

  task automatic pulse_sync();
    FRAME_SYNC = 1'b1;
    @(negedge ACLK);
    FRAME_SYNC = 1'b0;
  endtask

  // Acts as the write master for one line: waits for the request, answers with
  // WR_DONE `delay` cycles later, optionally raising FRAME_SYNC at cycle sync_at.
  task automatic serve_line(input int delay, input int sync_at, output bit seen,
                            output logic [31:0] adrs, output bit single, output bit held);
    seen = 1'b0; single = 1'b0; held = 1'b1; adrs = 32'hxxxx_xxxx;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      if (WR_START === 1'b1) begin
        seen = 1'b1;
        adrs = WR_ADRS;
      end
    end
    if (seen) begin
      for (int i = 1; i <= delay; i++) begin
        @(negedge ACLK);
        FRAME_SYNC = 1'b0;
        if (i == 1) single = (WR_START === 1'b0);
        if (WR_ADRS !== adrs) held = 1'b0;
        if (i == delay) WR_DONE = 1'b1;
        if (i == sync_at) FRAME_SYNC = 1'b1;
      end
      @(negedge ACLK);
      WR_DONE = 1'b0;
      FRAME_SYNC = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 ARESET = 1'b1;
    #1;
    checks++; if (WR_START !== 1'b0) begin errors++; $display("FAIL reset_wr_start: got %b expected 0", WR_START); end
    checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", FRAME_DONE); end
    checks++; if (OVERRUN !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", OVERRUN); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    checks++; if (WR_BUF_IDX !== 2'd0) begin errors++; $display("FAIL reset_wr_buf: got %0d expected 0", WR_BUF_IDX); end
    checks++; if (LAST_BUF_IDX !== 2'd2) begin errors++; $display("FAIL reset_last_buf: got %0d expected 2", LAST_BUF_IDX); end
    checks++; if (WR_ADRS !== BASE) begin errors++; $display("FAIL reset_wr_adrs: got %h expected %h", WR_ADRS, BASE); end
    checks++; if (WR_LEN !== 32'(LBYTES)) begin errors++; $display("FAIL reset_wr_len: got %0d expected %0d", WR_LEN, LBYTES); end
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++; if (BUSY !== 1'b0 || WR_START !== 1'b0) begin errors++; $display("FAIL reset_idle_no_sync: got busy=%b start=%b expected 0 0", BUSY, WR_START); end
    m_buf = 0; m_last = 2;
  endtask

  task automatic test_normal_frame();
    bit seen, single, held; logic [31:0] adrs; int fd0;
    apply_reset();
    fd0 = fd_count;
    pulse_sync();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL normal_busy: got %b expected 1", BUSY); end
    for (int ln = 0; ln < NLINES; ln++) begin
      serve_line(5, -1, seen, adrs, single, held);
      checks++; if (!seen || adrs !== exp_addr(m_buf, ln)) begin errors++; $display("FAIL normal_adrs line %0d: got seen=%b %h expected %h", ln, seen, adrs, exp_addr(m_buf, ln)); end
      checks++; if (!single || !held) begin errors++; $display("FAIL normal_pulse_hold line %0d: got single=%b held=%b expected 1 1", ln, single, held); end
      if (ln < NLINES - 1) begin
        checks++; if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL normal_early_done line %0d: got %b expected 0", ln, FRAME_DONE); end
      end
    end
    checks++; if (FRAME_DONE !== 1'b1) begin errors++; $display("FAIL normal_frame_done: got %b expected 1", FRAME_DONE); end
    @(negedge ACLK);
    m_last = m_buf; m_buf = next_buf(m_buf, 2);
    checks++; if (FRAME_DONE !== 1'b0 || fd_count != fd0 + 1) begin errors++; $display("FAIL normal_done_pulse: got done=%b pulses=%0d expected 0 1", FRAME_DONE, fd_count - fd0); end
    checks++; if (WR_BUF_IDX !== 2'(m_buf) || LAST_BUF_IDX !== 2'(m_last)) begin errors++; $display("FAIL normal_rotate: got wr=%0d last=%0d expected %0d %0d", WR_BUF_IDX, LAST_BUF_IDX, m_buf, m_last); end
    checks++; if (BUSY !== 1'b0 || OVERRUN !== 1'b0) begin errors++; $display("FAIL normal_idle: got busy=%b overrun=%b expected 0 0", BUSY, OVERRUN); end
  endtask

  task automatic test_starvation();
    bit seen; logic [31:0] adrs; int ws0;
    apply_reset();
    FIFO_RD_COUNT = 11'd7;
    ws0 = ws_count;
    pulse_sync();
    repeat (20) @(negedge ACLK);
    checks++; if (ws_count != ws0 || BUSY !== 1'b1) begin errors++; $display("FAIL starve_no_start: got starts=%0d busy=%b expected 0 1", ws_count - ws0, BUSY); end
    FIFO_RD_COUNT = 11'd8;
    seen = 1'b0; adrs = 32'h0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge ACLK);
      if (WR_START === 1'b1) begin seen = 1'b1; adrs = WR_ADRS; end
    end
    checks++; if (!seen || adrs !== exp_addr(0, 0)) begin errors++; $display("FAIL starve_release: got seen=%b %h expected 1 %h", seen, adrs, exp_addr(0, 0)); end
  endtask

  task automatic test_rotation_skip();
    bit seen, single, held; logic [31:0] adrs;
    apply_reset();
    RD_ACTIVE_IDX = 2'd1;
    pulse_sync();
    for (int ln = 0; ln < NLINES; ln++) begin
      serve_line(2, -1, seen, adrs, single, held);
      checks++; if (!seen || adrs !== exp_addr(m_buf, ln)) begin errors++; $display("FAIL rot_adrs line %0d: got %h expected %h", ln, adrs, exp_addr(m_buf, ln)); end
    end
    @(negedge ACLK);
    m_last = m_buf; m_buf = next_buf(m_buf, 1);
    checks++; if (WR_BUF_IDX !== 2'(m_buf) || LAST_BUF_IDX !== 2'(m_last)) begin errors++; $display("FAIL rot_skip: got wr=%0d last=%0d expected %0d %0d", WR_BUF_IDX, LAST_BUF_IDX, m_buf, m_last); end
    pulse_sync();
    serve_line(2, -1, seen, adrs, single, held);
    checks++; if (!seen || adrs !== exp_addr(m_buf, 0)) begin errors++; $display("FAIL rot_next_base: got %h expected %h", adrs, exp_addr(m_buf, 0)); end
  endtask

  task automatic test_resync();
    bit seen, single, held; logic [31:0] adrs; int fd0;
    apply_reset();
    fd0 = fd_count;
    pulse_sync();
    for (int ln = 0; ln < 3; ln++) begin
      serve_line(5, (ln == 2) ? 2 : -1, seen, adrs, single, held);
      checks++; if (!seen || adrs !== exp_addr(0, ln)) begin errors++; $display("FAIL resync_pre line %0d: got %h expected %h", ln, adrs, exp_addr(0, ln)); end
    end
    checks++; if (OVERRUN !== 1'b1 || fd_count != fd0 || FRAME_DONE !== 1'b0) begin errors++; $display("FAIL resync_flag: got overrun=%b pulses=%0d expected 1 0", OVERRUN, fd_count - fd0); end
    for (int ln = 0; ln < NLINES; ln++) begin
      serve_line(3, -1, seen, adrs, single, held);
      checks++; if (!seen || adrs !== exp_addr(0, ln)) begin errors++; $display("FAIL resync_restart line %0d: got %h expected %h", ln, adrs, exp_addr(0, ln)); end
    end
    @(negedge ACLK);
    checks++; if (fd_count != fd0 + 1 || OVERRUN !== 1'b1 || WR_BUF_IDX !== 2'd1) begin errors++; $display("FAIL resync_end: got pulses=%0d overrun=%b wr=%0d expected 1 1 1", fd_count - fd0, OVERRUN, WR_BUF_IDX); end
  endtask

  task automatic test_coincident();
    bit seen, single, held; logic [31:0] adrs;
    apply_reset();
    pulse_sync();
    for (int ln = 0; ln < NLINES; ln++) begin
      serve_line(3, (ln == NLINES - 1) ? 3 : -1, seen, adrs, single, held);
      checks++; if (!seen || adrs !== exp_addr(m_buf, ln)) begin errors++; $display("FAIL coinc_adrs line %0d: got %h expected %h", ln, adrs, exp_addr(m_buf, ln)); end
    end
    checks++; if (FRAME_DONE !== 1'b1 || OVERRUN !== 1'b1) begin errors++; $display("FAIL coinc_done: got done=%b overrun=%b expected 1 1", FRAME_DONE, OVERRUN); end
    @(negedge ACLK);
    m_last = m_buf; m_buf = next_buf(m_buf, 2);
    checks++; if (WR_BUF_IDX !== 2'(m_buf)) begin errors++; $display("FAIL coinc_buf: got %0d expected %0d", WR_BUF_IDX, m_buf); end
    serve_line(3, -1, seen, adrs, single, held);
    checks++; if (!seen || adrs !== exp_addr(m_buf, 0)) begin errors++; $display("FAIL coinc_autostart: got seen=%b %h expected 1 %h", seen, adrs, exp_addr(m_buf, 0)); end
  endtask

  task automatic test_reset_mid_burst();
    bit seen, single, held; logic [31:0] adrs; int ws0;
    apply_reset();
    pulse_sync();
    for (int ln = 0; ln < NLINES; ln++) serve_line(2, -1, seen, adrs, single, held);
    @(negedge ACLK);
    m_last = m_buf; m_buf = next_buf(m_buf, 2);
    pulse_sync();
    serve_line(4, 1, seen, adrs, single, held);
    checks++; if (!seen || adrs !== exp_addr(m_buf, 0) || OVERRUN !== 1'b1) begin errors++; $display("FAIL rstmid_setup: got %h overrun=%b expected %h 1", adrs, OVERRUN, exp_addr(m_buf, 0)); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge ACLK);
      if (WR_START === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_restart_req: got no request expected one"); end
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    checks++; if (WR_START !== 1'b0 || FRAME_DONE !== 1'b0 || OVERRUN !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got start=%b done=%b overrun=%b busy=%b expected 0 0 0 0", WR_START, FRAME_DONE, OVERRUN, BUSY); end
    checks++; if (WR_BUF_IDX !== 2'd0 || LAST_BUF_IDX !== 2'd2 || WR_ADRS !== BASE || WR_LEN !== 32'(LBYTES)) begin errors++; $display("FAIL rstmid_values: got wr=%0d last=%0d adrs=%h len=%0d expected 0 2 %h %0d", WR_BUF_IDX, LAST_BUF_IDX, WR_ADRS, WR_LEN, BASE, LBYTES); end
    @(negedge ACLK);
    ARESET = 1'b0;
    m_buf = 0; m_last = 2;
    ws0 = ws_count;
    @(negedge ACLK); WR_DONE = 1'b1;
    @(negedge ACLK); WR_DONE = 1'b0;
    repeat (15) @(negedge ACLK);
    checks++; if (ws_count != ws0 || BUSY !== 1'b0 || FRAME_DONE !== 1'b0) begin errors++; $display("FAIL rstmid_stale_done: got starts=%0d busy=%b expected 0 0", ws_count - ws0, BUSY); end
    pulse_sync();
    serve_line(2, -1, seen, adrs, single, held);
    checks++; if (!seen || adrs !== exp_addr(0, 0)) begin errors++; $display("FAIL rstmid_fresh: got %h expected %h", adrs, exp_addr(0, 0)); end
  endtask

  task automatic test_random_frames();
    apply_reset();
    for (int f = 0; f < 6; f++) begin
      int line, cd, rd;
      bit prev_ok, got_done;
      line = 0; cd = 0; got_done = 1'b0;
      rd = $urandom_range(0, 2);
      RD_ACTIVE_IDX = 2'(rd);
      FRAME_SYNC = 1'b1;
      prev_ok = 1'b0;
      for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
        @(negedge ACLK);
        FRAME_SYNC = 1'b0;
        WR_DONE = 1'b0;
        if (WR_START === 1'b1) begin
          checks++; if (!prev_ok) begin errors++; $display("FAIL rand_fifo_rule frame %0d: got request with fifo/ready low expected none", f); end
          checks++; if (WR_ADRS !== exp_addr(m_buf, line)) begin errors++; $display("FAIL rand_adrs frame %0d line %0d: got %h expected %h", f, line, WR_ADRS, exp_addr(m_buf, line)); end
          cd = $urandom_range(1, 6);
        end else if (cd > 0) begin
          cd--;
          if (cd == 0) begin WR_DONE = 1'b1; line++; end
        end
        if (FRAME_DONE === 1'b1) got_done = 1'b1;
        FIFO_RD_COUNT = 11'($urandom_range(5, 12));
        WR_READY = ($urandom_range(0, 3) != 0);
        prev_ok = (FIFO_RD_COUNT >= 11'd8) && WR_READY;
      end
      checks++; if (!got_done || line != NLINES) begin errors++; $display("FAIL rand_frame_done frame %0d: got done=%b lines=%0d expected 1 %0d", f, got_done, line, NLINES); end
      @(negedge ACLK);
      m_last = m_buf; m_buf = next_buf(m_buf, rd);
      checks++; if (WR_BUF_IDX !== 2'(m_buf) || LAST_BUF_IDX !== 2'(m_last)) begin errors++; $display("FAIL rand_rotate frame %0d: got wr=%0d last=%0d expected %0d %0d", f, WR_BUF_IDX, LAST_BUF_IDX, m_buf, m_last); end
    end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_starvation();
    test_rotation_skip();
    test_resync();
    test_coincident();
    test_reset_mid_burst();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vid_wr_scheduler.md
VID_WR_SCHEDULER -- requirements
Module: vid_wr_scheduler

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- BASE_ADDR, 32'h0100_0000, byte address of frame buffer 0.
- FRAME_STRIDE, 32'h0040_0000, byte distance between frame buffers.
- LINE_BYTES, 5120, bytes per video line; multiple of 8.
- LINES, 720, lines per frame.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- ACLK, in, 1, single clock.
- ARESET, in, 1, asynchronous active-high reset.
- FRAME_SYNC, in, 1, one-cycle start-of-frame pulse, ACLK domain.
- FIFO_RD_COUNT, in, 11, 64-bit words held in the upstream pixel FIFO.
- WR_READY, in, 1, AXI write master idle.
- WR_START, out, 1, one-cycle burst request to the write master.
- WR_ADRS, out, 32, byte address of the requested line.
- WR_LEN, out, 32, byte length of the requested line.
- WR_DONE, in, 1, one-cycle completion pulse from the write master.
- RD_ACTIVE_IDX, in, 2, buffer index currently scanned by the read side.
- WR_BUF_IDX, out, 2, buffer being written.
- LAST_BUF_IDX, out, 2, most recent fully written buffer.
- FRAME_DONE, out, 1, one-cycle pulse on frame completion.
- OVERRUN, out, 1, sticky flag for a FRAME_SYNC received mid-frame.
- BUSY, out, 1, high whenever the state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, WAIT_DATA, START, WAIT_DONE and FRAME_END, encoded in 3 bits.
REQ-004 IDLE SHALL move to WAIT_DATA on FRAME_SYNC, with line counter set to 0 and line address set to BASE_ADDR + WR_BUF_IDX*FRAME_STRIDE.
REQ-005 WAIT_DATA SHALL move to START when FIFO_RD_COUNT >= LINE_BYTES/8 and WR_READY=1.
REQ-006 In START, WR_START SHALL be 1 for exactly one cycle, with WR_ADRS and WR_LEN valid in the same cycle; the next state SHALL be WAIT_DONE.
REQ-007 WR_ADRS and WR_LEN SHALL hold their values from START until WR_DONE.
REQ-008 WR_LEN SHALL equal LINE_BYTES at all times.
REQ-009 In WAIT_DONE, on WR_DONE the line counter SHALL increment and the line address SHALL advance by LINE_BYTES.
- The line address SHALL use an accumulator; no multiplier.
- If the incremented count equals LINES, the next state SHALL be FRAME_END; otherwise WAIT_DATA.
REQ-010 FRAME_END SHALL last one cycle and SHALL:
- pulse FRAME_DONE;
- set LAST_BUF_IDX to WR_BUF_IDX;
- advance WR_BUF_IDX and return to IDLE.
REQ-011 Buffer advance SHALL use modulo-3 order 0->1->2->0.
- If the candidate index equals RD_ACTIVE_IDX, the index after it SHALL be used instead.
- The new WR_BUF_IDX SHALL never equal RD_ACTIVE_IDX or the outgoing LAST_BUF_IDX.
- Index value 3 SHALL never be produced.
REQ-012 FRAME_SYNC in WAIT_DATA or START SHALL set OVERRUN and restart the frame at line 0 of the same buffer.
- In START, the WR_START pulse of that cycle SHALL still be issued, and the restart SHALL take effect after its WR_DONE.
REQ-013 FRAME_SYNC in WAIT_DONE SHALL set OVERRUN and a resync-pending flag.
- On the following WR_DONE, the block SHALL restart at line 0 of the same buffer and SHALL clear the pending flag.
- No FRAME_DONE pulse SHALL occur for the aborted frame.
REQ-014 FRAME_SYNC coincident with the final WR_DONE SHALL:
- complete the frame through FRAME_END;
- set OVERRUN;
- start the next frame from IDLE without waiting for another FRAME_SYNC.
REQ-015 WR_DONE received outside WAIT_DONE SHALL be ignored.
REQ-016 FRAME_SYNC in FRAME_END SHALL be held pending and consumed in IDLE on the next cycle.
REQ-017 OVERRUN SHALL clear only on reset.
REQ-018 At least one line-time of FIFO data SHALL be present before any request; the block SHALL never issue WR_START while FIFO_RD_COUNT < LINE_BYTES/8.

Reset
REQ-019 On ARESET=1, asynchronously:
- state SHALL be IDLE;
- WR_START, FRAME_DONE, OVERRUN, BUSY SHALL be 0;
- WR_BUF_IDX SHALL be 0;
- LAST_BUF_IDX SHALL be 2;
- WR_ADRS SHALL be BASE_ADDR;
- WR_LEN SHALL be LINE_BYTES;
- line counter and pending flags SHALL be 0.
REQ-020 Reset mid-burst SHALL abandon the line; any stale WR_DONE after release SHALL be ignored, per REQ-015.

Verification
REQ-021 The bench SHALL cover these scenarios (LINES=4, LINE_BYTES=64 unless stated):
- Normal frame: FRAME_SYNC, FIFO_RD_COUNT=8, WR_DONE 5 cycles after each WR_START -> 4 WR_START pulses at 0x01000000, +0x40, +0x80, +0xC0; then FRAME_DONE, LAST_BUF_IDX=0, WR_BUF_IDX=1.
- Data starvation: FIFO_RD_COUNT=7 -> no WR_START; raise to 8 -> WR_START within 2 cycles.
- Rotation skip: WR_BUF_IDX=0, RD_ACTIVE_IDX=1 at frame end -> WR_BUF_IDX=2; next frame's first WR_ADRS=0x01800000.
- Mid-frame resync: FRAME_SYNC during line-2 WAIT_DONE -> OVERRUN=1, no FRAME_DONE; after WR_DONE the next WR_ADRS restarts at the same buffer base.
- Coincident final WR_DONE and FRAME_SYNC -> FRAME_DONE pulses, OVERRUN=1; next frame starts with no additional FRAME_SYNC.
- Reset asserted in WAIT_DONE, then WR_DONE after release -> outputs at REQ-019 values, no WR_START until a fresh FRAME_SYNC.
